// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register of the MIPS32 core, plus the EX ALU-control decoder and MEM branch-taken gate.
// Latency: registered fields 1 cycle; sal_alu_control and branch_taken are combinational.
// Backpressure: none; no stall or enable, so the stage captures every cycle. Optional macro EXMEM_BRANCH_FLUSH_EN squashes controls on a taken branch.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              zero_IN,
    input  logic              branch,
    input  logic              memread,
    input  logic              memtoreg,
    input  logic              memwrite,
    input  logic              regwrite,
    input  logic [DATA_W-1:0] Add_proxDir_IN,
    input  logic [DATA_W-1:0] PCplus4_B,
    input  logic [DATA_W-1:0] DR2_IN,
    input  logic [DATA_W-1:0] Alu_result_IN,
    input  logic [REG_W-1:0]  WriteRegister_IN,
    input  logic [5:0]        instruccion_FNC,
    input  logic [1:0]        ALUop,
    output logic [3:0]        sal_alu_control,
    output logic              zero_OUT,
    output logic [DATA_W-1:0] Add_proxDir_OUT,
    output logic [DATA_W-1:0] PCplus4_B_OUT,
    output logic [DATA_W-1:0] DR2_OUT,
    output logic [DATA_W-1:0] Alu_result_OUT,
    output logic [REG_W-1:0]  WriteRegister,
    output logic              o_branch,
    output logic              o_memread,
    output logic              o_memtoreg,
    output logic              o_memwrite,
    output logic              o_regwrite,
    output logic              branch_taken
);

    // ALU operation codes driven to EX
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_BAD = 4'b1111;

    // Squash request for the instruction entering MEM behind a taken branch
    logic flush;
`ifdef EXMEM_BRANCH_FLUSH_EN
    assign flush = branch_taken;
`else
    assign flush = 1'b0;
`endif

    // Decode ALUop class and, for R-type, the funct field into an ALU operation
    always_comb begin
        sal_alu_control = ALU_BAD;
        case (ALUop)
            2'b00: sal_alu_control = ALU_ADD;
            2'b01: sal_alu_control = ALU_SUB;
            2'b11: sal_alu_control = ALU_AND;
            default: begin
                case (instruccion_FNC)
                    6'b100000: sal_alu_control = ALU_ADD;
                    6'b100010: sal_alu_control = ALU_SUB;
                    6'b100100: sal_alu_control = ALU_AND;
                    6'b100101: sal_alu_control = ALU_OR;
                    6'b101010: sal_alu_control = ALU_SLT;
                    6'b100111: sal_alu_control = ALU_NOR;
                    default:   sal_alu_control = ALU_BAD;
                endcase
            end
        endcase
    end

    // Data, PC and destination fields: clear on reset, otherwise capture every edge
    always_ff @(posedge clock) begin
        if (!reset) begin
            Add_proxDir_OUT <= '0;
            PCplus4_B_OUT   <= '0;
            DR2_OUT         <= '0;
            Alu_result_OUT  <= '0;
            WriteRegister   <= '0;
        end else begin
            Add_proxDir_OUT <= Add_proxDir_IN;
            PCplus4_B_OUT   <= PCplus4_B;
            DR2_OUT         <= DR2_IN;
            Alu_result_OUT  <= Alu_result_IN;
            WriteRegister   <= WriteRegister_IN;
        end
    end

    // Control bits and zero flag: clear on reset or when squashing a wrong-path instruction
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            zero_OUT   <= 1'b0;
            o_branch   <= 1'b0;
            o_memread  <= 1'b0;
            o_memtoreg <= 1'b0;
            o_memwrite <= 1'b0;
            o_regwrite <= 1'b0;
        end else begin
            zero_OUT   <= zero_IN;
            o_branch   <= branch;
            o_memread  <= memread;
            o_memtoreg <= memtoreg;
            o_memwrite <= memwrite;
            o_regwrite <= regwrite;
        end
    end

    // PC select for IF: branch in MEM whose comparison came out equal
    assign branch_taken = o_branch & zero_OUT;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        zero_IN, branch, memread, memtoreg, memwrite, regwrite;
    logic [31:0] Add_proxDir_IN, PCplus4_B, DR2_IN, Alu_result_IN;
    logic [4:0]  WriteRegister_IN;
    logic [5:0]  instruccion_FNC;
    logic [1:0]  ALUop;
    logic [3:0]  sal_alu_control;
    logic        zero_OUT;
    logic [31:0] Add_proxDir_OUT, PCplus4_B_OUT, DR2_OUT, Alu_result_OUT;
    logic [4:0]  WriteRegister;
    logic        o_branch, o_memread, o_memtoreg, o_memwrite, o_regwrite;
    logic        branch_taken;

    int checks = 0;
    int errors = 0;

    ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clock(clock), .reset(reset), .zero_IN(zero_IN), .branch(branch),
        .memread(memread), .memtoreg(memtoreg), .memwrite(memwrite), .regwrite(regwrite),
        .Add_proxDir_IN(Add_proxDir_IN), .PCplus4_B(PCplus4_B), .DR2_IN(DR2_IN),
        .Alu_result_IN(Alu_result_IN), .WriteRegister_IN(WriteRegister_IN),
        .instruccion_FNC(instruccion_FNC), .ALUop(ALUop),
        .sal_alu_control(sal_alu_control), .zero_OUT(zero_OUT),
        .Add_proxDir_OUT(Add_proxDir_OUT), .PCplus4_B_OUT(PCplus4_B_OUT),
        .DR2_OUT(DR2_OUT), .Alu_result_OUT(Alu_result_OUT), .WriteRegister(WriteRegister),
        .o_branch(o_branch), .o_memread(o_memread), .o_memtoreg(o_memtoreg),
        .o_memwrite(o_memwrite), .o_regwrite(o_regwrite), .branch_taken(branch_taken)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ctl(input logic z, input logic b, input logic mr,
                           input logic mt, input logic mw, input logic rw);
        zero_IN = z; branch = b; memread = mr; memtoreg = mt; memwrite = mw; regwrite = rw;
    endtask

    // Check all registered outputs are cleared
    task automatic chk_cleared(input string tag);
        chk({tag, ".alu"}, Alu_result_OUT, 32'h0);
        chk({tag, ".dr2"}, DR2_OUT, 32'h0);
        chk({tag, ".add"}, Add_proxDir_OUT, 32'h0);
        chk({tag, ".pc4"}, PCplus4_B_OUT, 32'h0);
        chk({tag, ".wr"}, {27'h0, WriteRegister}, 32'h0);
        chk({tag, ".ctl"}, {26'h0, zero_OUT, o_branch, o_memread, o_memtoreg, o_memwrite, o_regwrite}, 32'h0);
        chk({tag, ".bt"}, {31'h0, branch_taken}, 32'h0);
    endtask

    typedef struct { logic [1:0] op; logic [5:0] fn; logic [3:0] exp; } alu_vec_t;
    alu_vec_t alu_vecs [12] = '{
        '{2'b00, 6'h3F, 4'b0010}, '{2'b01, 6'h20, 4'b0110}, '{2'b11, 6'h25, 4'b0000},
        '{2'b10, 6'h20, 4'b0010}, '{2'b10, 6'h22, 4'b0110}, '{2'b10, 6'h24, 4'b0000},
        '{2'b10, 6'h25, 4'b0001}, '{2'b10, 6'h2A, 4'b0111}, '{2'b10, 6'h27, 4'b1100},
        '{2'b10, 6'h3F, 4'b1111}, '{2'b10, 6'h00, 4'b1111}, '{2'b00, 6'h22, 4'b0010}
    };

    initial begin
        // Reset with every input nonzero
        reset = 1'b0;
        set_ctl(1, 1, 1, 1, 1, 1);
        Add_proxDir_IN = 32'hFFFF_FFFF; PCplus4_B = 32'h1234_5678;
        DR2_IN = 32'hA5A5_A5A5; Alu_result_IN = 32'h5A5A_5A5A;
        WriteRegister_IN = 5'd31; instruccion_FNC = 6'h20; ALUop = 2'b10;
        tick();
        tick();
        chk_cleared("reset");

        // Release reset; outputs hold until the capturing edge
        reset = 1'b1;
        set_ctl(0, 0, 0, 1, 0, 1);
        Alu_result_IN = 32'h0000_0010; DR2_IN = 32'hDEAD_BEEF; WriteRegister_IN = 5'd9;
        Add_proxDir_IN = 32'h0; PCplus4_B = 32'h0000_0104;
        #1;
        chk("pre_cap.alu", Alu_result_OUT, 32'h0);
        tick();
        chk("cap.alu", Alu_result_OUT, 32'h0000_0010);
        chk("cap.dr2", DR2_OUT, 32'hDEAD_BEEF);
        chk("cap.wr", {27'h0, WriteRegister}, 32'd9);
        chk("cap.pc4", PCplus4_B_OUT, 32'h0000_0104);
        chk("cap.ctl", {26'h0, zero_OUT, o_branch, o_memread, o_memtoreg, o_memwrite, o_regwrite}, 32'b000101);

        // Taken branch
        set_ctl(1, 1, 0, 0, 1, 1);
        Add_proxDir_IN = 32'h0000_0040; Alu_result_IN = 32'h0000_0020;
        #1;
        chk("pre_br.alu", Alu_result_OUT, 32'h0000_0010);
        chk("pre_br.bt", {31'h0, branch_taken}, 32'h0);
        tick();
        chk("br.bt", {31'h0, branch_taken}, 32'h1);
        chk("br.add", Add_proxDir_OUT, 32'h0000_0040);
        chk("br.alu", Alu_result_OUT, 32'h0000_0020);

        // Instruction behind the taken branch
        set_ctl(0, 0, 0, 0, 1, 1);
        Alu_result_IN = 32'h0000_0030; WriteRegister_IN = 5'd3;
        tick();
        chk("post_br.alu", Alu_result_OUT, 32'h0000_0030);
        chk("post_br.wr", {27'h0, WriteRegister}, 32'd3);
`ifdef EXMEM_BRANCH_FLUSH_EN
        chk("post_br.regwrite", {31'h0, o_regwrite}, 32'h0);
        chk("post_br.memwrite", {31'h0, o_memwrite}, 32'h0);
`else
        chk("post_br.regwrite", {31'h0, o_regwrite}, 32'h1);
        chk("post_br.memwrite", {31'h0, o_memwrite}, 32'h1);
`endif
        chk("post_br.branch", {31'h0, o_branch}, 32'h0);
        chk("post_br.bt", {31'h0, branch_taken}, 32'h0);

        // Branch not taken: zero clear
        set_ctl(0, 1, 1, 0, 0, 0);
        Add_proxDir_IN = 32'h0000_0080;
        tick();
        chk("nt.bt", {31'h0, branch_taken}, 32'h0);
        chk("nt.ctl", {26'h0, zero_OUT, o_branch, o_memread, o_memtoreg, o_memwrite, o_regwrite}, 32'b011000);
        chk("nt.add", Add_proxDir_OUT, 32'h0000_0080);

        // Mid-stream reset for one edge
        set_ctl(0, 0, 1, 1, 0, 1);
        Alu_result_IN = 32'h0000_1000; DR2_IN = 32'h0000_0111; WriteRegister_IN = 5'd7;
        tick();
        chk("ms_a.alu", Alu_result_OUT, 32'h0000_1000);
        reset = 1'b0;
        Alu_result_IN = 32'h0000_2000; WriteRegister_IN = 5'd8;
        tick();
        chk_cleared("ms_rst");
        reset = 1'b1;
        Alu_result_IN = 32'h0000_3000; DR2_IN = 32'h0000_0333; WriteRegister_IN = 5'd10;
        tick();
        chk("ms_b.alu", Alu_result_OUT, 32'h0000_3000);
        chk("ms_b.dr2", DR2_OUT, 32'h0000_0333);
        chk("ms_b.wr", {27'h0, WriteRegister}, 32'd10);
        chk("ms_b.ctl", {26'h0, zero_OUT, o_branch, o_memread, o_memtoreg, o_memwrite, o_regwrite}, 32'b001101);

        // ALU control sweep (combinational)
        foreach (alu_vecs[i]) begin
            ALUop = alu_vecs[i].op;
            instruccion_FNC = alu_vecs[i].fn;
            #1;
            chk($sformatf("aluctl[%0d]", i), {28'h0, sal_alu_control}, {28'h0, alu_vecs[i].exp});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline boundary of the 5-stage MIPS32 core. Registers the EX-stage results and control bits for the MEM stage.
- Also holds two combinational helpers:
  - ALU control decoder for EX (ALUop + funct -> 4-bit ALU operation).
  - Branch-taken AND for the PC select in IF (MEM-stage branch & zero).
- Sits between the Execution stage and MemoryAccess/MEM_WB.

Parameters:
- DATA_W, 32, width of address, data and PC paths
- REG_W, 5, register-index width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- zero_IN  in  1  ALU zero flag from EX
- branch  in  1  ID/EX branch control
- memread  in  1  ID/EX memory-read control
- memtoreg  in  1  ID/EX memory-to-register control
- memwrite  in  1  ID/EX memory-write control
- regwrite  in  1  ID/EX register-write control
- Add_proxDir_IN  in  DATA_W  branch target from EX adder
- PCplus4_B  in  DATA_W  PC+4 carried from ID/EX
- DR2_IN  in  DATA_W  store data (rt value)
- Alu_result_IN  in  DATA_W  ALU result
- WriteRegister_IN  in  REG_W  destination register
- instruccion_FNC  in  6  funct field (sign_extend[5:0])
- ALUop  in  2  ALU op class from ID/EX
- sal_alu_control  out  4  ALU operation code (combinational)
- zero_OUT  out  1  registered zero
- Add_proxDir_OUT  out  DATA_W  registered branch target
- PCplus4_B_OUT  out  DATA_W  registered PC+4
- DR2_OUT  out  DATA_W  registered store data
- Alu_result_OUT  out  DATA_W  registered ALU result / memory address
- WriteRegister  out  REG_W  registered destination register
- o_branch, o_memread, o_memtoreg, o_memwrite, o_regwrite  out  1 each  registered controls
- branch_taken  out  1  o_branch AND zero_OUT (combinational)

Behaviour:
- All registered outputs update on the rising clock edge with 1-cycle latency. There is no enable or stall; the stage captures every cycle.
- Reset: when reset==0 at a rising edge, every registered output is 0 (data, PCs, WriteRegister, zero, all control bits). Reset has priority over capture. Deasserting reset mid-run resumes normal capture on the next edge.
- branch_taken is combinational from the registered o_branch and zero_OUT. It is 0 during and immediately after reset.
- ALU control, purely combinational, no clock/reset dependence:
  - ALUop=00 -> 0010 (add; lw/sw/addi).
  - ALUop=01 -> 0110 (sub; beq).
  - ALUop=11 -> 0000 (and; andi).
  - ALUop=10 decodes funct:
    - 100000 -> 0010 add
    - 100010 -> 0110 sub
    - 100100 -> 0000 and
    - 100101 -> 0001 or
    - 101010 -> 0111 slt
    - 100111 -> 1100 nor
    - any other funct -> 1111 (invalid; EX treats it as result 0).
- Funct bits are ignored unless ALUop=10.
- No X propagation: every output is fully defined for all input combinations.

Optional Feature:
- Macro: EXMEM_BRANCH_FLUSH_EN.
- Defined: if branch_taken==1 at a rising edge (and reset==1), the stage captures a bubble. All five control outputs and zero_OUT become 0; the data/PC/WriteRegister fields still capture normally. This squashes the wrong-path instruction entering MEM.
- Undefined: the stage captures normally regardless of branch_taken.

Test Plan:
- Reset: hold reset=0 over 2 edges with all inputs nonzero -> every registered output 0 and branch_taken=0. Release reset; next edge captures inputs.
- Capture: Alu_result_IN=0x0000_0010, DR2_IN=0xDEAD_BEEF, WriteRegister_IN=5'd9, regwrite=1, memtoreg=1 -> after one edge the outputs equal these values. On the same edge, outputs still show the previous values.
- Branch: branch=1, zero_IN=1, Add_proxDir_IN=0x0000_0040 -> after the edge, branch_taken=1 and Add_proxDir_OUT=0x40. With zero_IN=0 instead -> branch_taken=0.
- ALU control sweep:
  - ALUop=00 -> 0010; ALUop=01 -> 0110; ALUop=11 -> 0000.
  - ALUop=10 with funct 0x20/0x22/0x24/0x25/0x2A/0x27 -> 0010/0110/0000/0001/0111/1100.
  - ALUop=10, funct 0x3F -> 1111.
- Reset mid-stream: during back-to-back captures, assert reset=0 for one edge -> all outputs 0 that cycle, then normal capture resumes.
- With EXMEM_BRANCH_FLUSH_EN: branch_taken=1 while regwrite=1, memwrite=1 incoming -> next edge o_regwrite=0, o_memwrite=0, o_branch=0. Without the macro -> o_regwrite=1, o_memwrite=1.
